// File: rtl/rhd_frame_packetizer.sv
// Frames RHD per-channel sample words into AXI4-Stream packets for S2MM DMA:
// each frame is two magic words, a 32-bit timestamp and NUM_CH samples; TLAST ends a batch.
module rhd_frame_packetizer #(
  parameter int unsigned NUM_CH  = 32,
  parameter logic [63:0] MAGIC   = 64'hC691199927021942,
  parameter int unsigned BATCH_W = 8
) (
  input  logic               clk_dma,
  input  logic               rstn_dma,
  input  logic               en,
  input  logic [BATCH_W-1:0] batch_size,
  input  logic [31:0]        s_data,
  input  logic               s_first,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [31:0]        m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast,
  output logic               busy,
  output logic [7:0]         err_cnt
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIRST,
    MAGIC_LO,
    MAGIC_HI,
    TSTAMP,
    DATA
  } state_t;

  state_t state, state_nx;

  logic               en_q;
  logic [BATCH_W-1:0] batch_q;
  logic [BATCH_W-1:0] frame_cnt;
  logic [CH_W-1:0]    ch_idx;
  logic [31:0]        tstamp;
  logic [7:0]         err_q;

  logic               out_valid;
  logic [31:0]        out_data;
  logic               out_last;

  logic               can_load;
  logic               en_rise;
  logic               last_ch;
  logic               last_frame;
  logic               wf_stop;
  logic               data_fire;
  logic [BATCH_W-1:0] batch_eff;

  logic               ready_c;
  logic               load;
  logic [31:0]        load_data;
  logic               load_last;

  assign can_load   = !out_valid || m_axis_tready;
  assign en_rise    = en && !en_q;
  assign last_ch    = (ch_idx == CH_W'(NUM_CH - 1));
  assign last_frame = (frame_cnt == (batch_q - BATCH_W'(1)));
  assign batch_eff  = (batch_size == '0) ? BATCH_W'(1) : batch_size;
  // Between packets (no frame of a batch sent yet) a dropped enable ends the session.
  assign wf_stop    = !en && (frame_cnt == '0);
  assign data_fire  = (state == DATA) && s_valid && can_load;

  // State register
  always_ff @(posedge clk_dma or negedge rstn_dma) begin
    if (!rstn_dma) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (en) state_nx = WAIT_FIRST;
      end
      WAIT_FIRST: begin
        if (wf_stop) begin
          state_nx = IDLE;
        end else if (s_valid && s_first) begin
          // Magic low word loads straight from here when possible, so frames run back-to-back.
          state_nx = can_load ? MAGIC_HI : MAGIC_LO;
        end
      end
      MAGIC_LO: begin
        if (can_load) state_nx = MAGIC_HI;
      end
      MAGIC_HI: begin
        if (can_load) state_nx = TSTAMP;
      end
      TSTAMP: begin
        if (can_load) state_nx = DATA;
      end
      DATA: begin
        if (data_fire && last_ch) begin
          state_nx = (last_frame && !en) ? IDLE : WAIT_FIRST;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    ready_c   = 1'b0;
    load      = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    unique case (state)
      IDLE: begin
        ready_c = 1'b1;
      end
      WAIT_FIRST: begin
        if (wf_stop) begin
          ready_c = 1'b1;
        end else begin
          ready_c   = !s_first;
          load      = s_valid && s_first && can_load;
          load_data = MAGIC[31:0];
        end
      end
      MAGIC_LO: begin
        load      = can_load;
        load_data = MAGIC[31:0];
      end
      MAGIC_HI: begin
        load      = can_load;
        load_data = MAGIC[63:32];
      end
      TSTAMP: begin
        load      = can_load;
        load_data = tstamp;
      end
      DATA: begin
        ready_c   = can_load;
        load      = s_valid && can_load;
        load_data = s_data;
        load_last = last_ch && last_frame;
      end
      default: begin
        ready_c = 1'b0;
      end
    endcase
  end

  // Single output register: refills in the same cycle it hands off
  always_ff @(posedge clk_dma or negedge rstn_dma) begin
    if (!rstn_dma) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_last  <= load_last;
    end else if (m_axis_tready) begin
      out_valid <= 1'b0;
    end
  end

  // Session and framing counters
  always_ff @(posedge clk_dma or negedge rstn_dma) begin
    if (!rstn_dma) begin
      en_q      <= 1'b0;
      batch_q   <= BATCH_W'(1);
      frame_cnt <= '0;
      ch_idx    <= '0;
      tstamp    <= '0;
      err_q     <= '0;
    end else begin
      en_q <= en;

      if (((state == IDLE) && en) || (data_fire && last_ch && last_frame)) begin
        batch_q <= batch_eff;
      end

      if (data_fire) begin
        ch_idx <= last_ch ? '0 : ch_idx + CH_W'(1);
        if (last_ch) begin
          frame_cnt <= last_frame ? '0 : frame_cnt + BATCH_W'(1);
        end
      end

      if ((state == IDLE) && en_rise) begin
        tstamp <= '0;
      end else if (data_fire && last_ch) begin
        tstamp <= tstamp + 32'd1;
      end

      if ((state == IDLE) && en_rise) begin
        err_q <= '0;
      end else if (data_fire && s_first && (ch_idx != '0) && (err_q != '1)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  assign s_ready       = ready_c && rstn_dma;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_data;
  assign m_axis_tlast  = out_last;
  assign busy          = (state != IDLE);
  assign err_cnt       = err_q;

endmodule

// File: tb/tb_rhd_frame_packetizer.sv
// Directed bench for rhd_frame_packetizer: a free-running upstream frame source
// and an expected-word scoreboard built from hand-derived packet contents.
module tb_rhd_frame_packetizer;

  logic        clk_dma;
  logic        rstn_dma;
  logic        en;
  logic [7:0]  batch_size;
  logic [31:0] s_data;
  logic        s_first;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic [7:0]  err_cnt;

  rhd_frame_packetizer #(
    .NUM_CH (32),
    .MAGIC  (64'hC691199927021942),
    .BATCH_W(8)
  ) dut (
    .clk_dma      (clk_dma),
    .rstn_dma     (rstn_dma),
    .en           (en),
    .batch_size   (batch_size),
    .s_data       (s_data),
    .s_first      (s_first),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .err_cnt      (err_cnt)
  );

  initial begin
    clk_dma = 1'b0;
    forever #5 clk_dma = ~clk_dma;
  end

  int          errors = 0;
  int          checks = 0;
  int unsigned ch_ptr = 0;
  bit          bp_mode = 0;
  bit          inject5 = 0;
  bit          arm_inject = 0;
  int unsigned captured_run = 0;
  int unsigned drop_after = 0;
  int          cyc = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One packet: per frame magic low, magic high, timestamp, then 32 samples 0xA500|n
  task automatic push_packet(input int unsigned batch, input int unsigned ts0);
    for (int unsigned f = 0; f < batch; f++) begin
      exp_q.push_back({1'b0, 32'h27021942});
      exp_q.push_back({1'b0, 32'hC6911999});
      exp_q.push_back({1'b0, 32'(ts0 + f)});
      for (int unsigned n = 0; n < 32; n++) begin
        exp_q.push_back({(f == batch - 1) && (n == 31), 32'h0000A500 | n});
      end
    end
  endtask

  // Inputs change on the falling edge; handshakes are evaluated just after,
  // when everything is settled for the coming rising edge.
  task automatic tick();
    logic [32:0] e;
    @(negedge clk_dma);
    s_valid       = 1'b1;
    s_data        = 32'h0000A500 | ch_ptr;
    s_first       = (ch_ptr == 0) || (inject5 && ch_ptr == 5);
    m_axis_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (prev_stall) begin
      check("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
      check("stall_tdata", m_axis_tdata, prev_data);
      check("stall_tlast", 32'(m_axis_tlast), 32'(prev_last));
    end
    if (busy && m_axis_tvalid && !m_axis_tready) check("sready_stalled", 32'(s_ready), 32'd0);
    if (m_axis_tvalid && m_axis_tready) begin
      check("word_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tdata", m_axis_tdata, e[31:0]);
        check("tlast", 32'(m_axis_tlast), 32'(e[32]));
      end
      if (captured_run == 0) first_cyc = cyc;
      last_cyc = cyc;
      captured_run++;
      if (captured_run == drop_after) begin
        en = 1'b0;
        if (arm_inject) inject5 = 1'b1;
      end
    end
    if (s_valid && s_ready) begin
      if (inject5 && ch_ptr == 5) inject5 = 1'b0;
      ch_ptr = (ch_ptr + 1) % 32;
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;
    cyc++;
  endtask

  task automatic run_packet(input int unsigned batch_cfg, input int unsigned batch_eff,
                            input int unsigned npk, input int unsigned drop_at);
    int unsigned budget;
    int unsigned n;
    for (int unsigned p = 0; p < npk; p++) push_packet(batch_eff, p * batch_eff);
    budget       = 20 * exp_q.size() + 200;
    captured_run = 0;
    drop_after   = drop_at;
    batch_size   = 8'(batch_cfg);
    en           = 1'b1;
    n            = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    en = 1'b0;
    exp_q.delete();
    repeat (4) tick();
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int          idle_valid;
    int          idle_block;
    rstn_dma      = 1'b0;
    en            = 1'b0;
    batch_size    = 8'd2;
    s_data        = '0;
    s_first       = 1'b0;
    s_valid       = 1'b0;
    m_axis_tready = 1'b1;

    repeat (3) tick();
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_sready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    rstn_dma = 1'b1;
    repeat (3) tick();
    check("idle_sready", 32'(s_ready), 32'd1);

    // Basic packet, batch 2, continuous output
    run_packet(2, 2, 1, 1);
    check("basic_len", 32'(captured_run), 32'd70);
    check("no_gaps", 32'(last_cyc - first_cyc), 32'd69);

    // Backpressure: same sequence with random tready
    bp_mode = 1;
    run_packet(2, 2, 1, 1);
    check("bp_len", 32'(captured_run), 32'd70);
    bp_mode = 0;

    // Stop mid-packet after frame 1; packet must still complete
    run_packet(8, 8, 1, 35);
    check("stop_len", 32'(captured_run), 32'd280);
    idle_valid = 0;
    idle_block = 0;
    repeat (10000) begin
      tick();
      if (m_axis_tvalid) idle_valid++;
      if (!s_ready) idle_block++;
    end
    check("idle_no_output", 32'(idle_valid), 32'd0);
    check("idle_discard", 32'(idle_block), 32'd0);
    run_packet(2, 2, 1, 1);

    // Enable while upstream sits at channel 10
    n = 0;
    while (ch_ptr != 10 && n < 64) begin
      tick();
      n++;
    end
    check("reach_ch10", ch_ptr, 32'd10);
    run_packet(1, 1, 1, 1);

    // Misplaced s_first at channel 5 inside a frame
    arm_inject = 1;
    run_packet(2, 2, 1, 1);
    arm_inject = 0;
    check("err_cnt_one", 32'(err_cnt), 32'd1);

    // batch_size 0 acts as 1: two back-to-back single-frame packets
    run_packet(0, 1, 2, 36);
    check("batch0_len", 32'(captured_run), 32'd70);
    check("err_cleared", 32'(err_cnt), 32'd0);

    // Reset in the middle of DATA
    push_packet(2, 0);
    batch_size   = 8'd2;
    captured_run = 0;
    drop_after   = 1000;
    en           = 1'b1;
    n            = 0;
    while (captured_run < 10 && n < 200) begin
      tick();
      n++;
    end
    check("reached_data", 32'(captured_run), 32'd10);
    rstn_dma = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("mid_rst_sready", 32'(s_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
    exp_q.delete();
    prev_stall = 0;
    repeat (2) tick();
    batch_size = 8'd1;
    rstn_dma   = 1'b1;
    run_packet(1, 1, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
